dmem_mmio_responder: RTL
========================

// Module: dmem_mmio_responder
// PURPOSE
//  Memory-side responder for the processor data-memory port (address/data/wren -> q).
//  Routes ordinary addresses to the dmem syncram; serves a small MMIO window with an LED register,
//  a free-running cycle timer and a byte TX FIFO drained over a valid/ready handshake.
//  Sits between the processor dmem port and the dmem syncram; 1-cycle read latency on both paths.
// PARAMETERS
//  ADDR_WIDTH  12      processor word-address width
//  DATA_WIDTH  32      data word width
//  MMIO_BASE   12'hF00 first MMIO word address; window is MMIO_BASE..MMIO_BASE+'hFF
//  LED_WIDTH   16      width of LED register
//  FIFO_DEPTH  8       TX FIFO entries, power of two, >=2
// PORTS
//  clock        in   1          single clock, rising edge
//  reset        in   1          asynchronous, active-high
//  proc_address in   ADDR_WIDTH processor request address
//  proc_data    in   DATA_WIDTH processor write data
//  proc_wren    in   1          processor write enable
//  proc_q       out  DATA_WIDTH read data, valid 1 cycle after address
//  mem_address  out  ADDR_WIDTH to dmem syncram (= proc_address)
//  mem_data     out  DATA_WIDTH to dmem syncram (= proc_data)
//  mem_wren     out  1          proc_wren & ~in_mmio
//  mem_q        in   DATA_WIDTH from dmem syncram (registered-address, 1-cycle)
//  led_out      out  LED_WIDTH  LED register
//  tx_data      out  8          FIFO head byte
//  tx_valid     out  1          FIFO non-empty
//  tx_ready     in   1          consumer accepts head when tx_valid & tx_ready
// BEHAVIOUR
//  Decode: in_mmio = proc_address >= MMIO_BASE. Offsets: +0 LED (RW), +1 TIMER (RW, write clears),
//   +2 TXDATA (WO, push proc_data[7:0]; reads 0), +3 STATUS (RW). Other offsets: read 0, writes ignored.
//  Read path: sel_mmio_q <= in_mmio each edge; mmio_rdata_q <= decoded register value each edge;
//   proc_q = sel_mmio_q ? mmio_rdata_q : mem_q. Latency exactly 1 cycle for all addresses.
//  Writes take effect on the edge where proc_wren is high; a read of the same address in the next
//   cycle returns the new value. MMIO writes never reach dmem (mem_wren=0).
//  LED: led_out <= proc_data[LED_WIDTH-1:0] on write to +0.
//  TIMER: 32-bit, +1 every cycle, wraps 32'hFFFFFFFF -> 0; write to +1 loads 0 (beats increment).
//  STATUS read: bit31 overflow (sticky), bit8 full, bits[7:0] count. Any write to +3 clears overflow.
//  FIFO: pop when tx_valid & tx_ready. Push accepted when !full, or when full and pop same cycle.
//   Push to full FIFO with no pop: byte dropped, overflow<=1. Push+pop on empty: push only
//   (tx_valid low that cycle). tx_valid rises the cycle after first push. Pointers wrap modulo DEPTH.
//  Reset (async, any time): led_out=0, timer=0, FIFO emptied (tx_valid=0, count=0), overflow=0,
//   sel_mmio_q=0, mmio_rdata_q=0, so proc_q=mem_q. tx_data=0 while empty.
// CONFIGURATION
//  MMIO_TIMER_EN defined: timer present as above.
//  MMIO_TIMER_EN undefined: no timer flops; offset +1 reads 0, writes ignored.
// STRUCTURE
//  Package dmem_mmio_pkg: MMIO offset constants (OFS_LED/OFS_TIMER/OFS_TXDATA/OFS_STATUS),
//   STATUS bit positions, default MMIO_BASE.
//  Sub-module mmio_tx_fifo (DEPTH, width 8): push/pop/full/empty/count/head; overflow kept in top.
// TESTING
//  1 Write 32'h1234 to addr 12'h010, read 12'h010 -> mem_wren pulses once, proc_q=32'h1234 cycle+1.
//  2 Write 32'hABCD to 12'hF00 -> led_out=16'hABCD next edge, mem_wren stays 0, read back 32'hABCD.
//  3 Write 12'hF01, then read 12'hF01 each cycle -> values 0,1,2...; force timer to 32'hFFFFFFFF
//    -> next read 0. Without MMIO_TIMER_EN -> reads 0.
//  4 tx_ready=0, push 9 bytes 8'h01..8'h09 -> STATUS = 32'h8000_0108, tx_data=8'h01; raise
//    tx_ready -> bytes 01..08 in order, tx_valid falls after 8th; write STATUS -> bit31 clears.
//  5 FIFO full, push and pop same cycle -> accepted, count stays 8, overflow stays 0.
//  6 Assert reset mid-drain with 3 bytes queued -> tx_valid=0, led_out=0, STATUS reads 0 after release.

Source files
------------

// File: rtl/dmem_mmio_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Package : dmem_mmio_pkg
//  Shared MMIO offsets, STATUS layout and default window base.
//  Rev 1.0
// ============================================================================
package dmem_mmio_pkg;

  localparam int OFS_LED    = 0;
  localparam int OFS_TIMER  = 1;
  localparam int OFS_TXDATA = 2;
  localparam int OFS_STATUS = 3;

  localparam int STATUS_OVF_BIT   = 31;
  localparam int STATUS_FULL_BIT  = 8;
  localparam int STATUS_COUNT_LSB = 0;
  localparam int STATUS_COUNT_W   = 8;

  localparam logic [11:0] DEFAULT_MMIO_BASE = 12'hF00;

endpackage
`default_nettype wire

// File: rtl/dmem_mmio_responder_if.sv
`default_nettype none
// ============================================================================
//  Interface : dmem_mmio_responder_if
//  Processor data-memory port: address/data/wren request, q read data.
//  Rev 1.0
// ============================================================================
interface dmem_mmio_responder_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;
  logic                  wren;
  logic [DATA_WIDTH-1:0] q;

  modport master (output address, output data, output wren, input  q);
  modport slave  (input  address, input  data, input  wren, output q);
endinterface
`default_nettype wire

// File: rtl/dmem_mmio_responder_fifo.sv
`default_nettype none
// ============================================================================
//  Module : mmio_tx_fifo
//  Small synchronous FIFO; head reads zero while empty.
//  Rev 1.0
// ============================================================================
module mmio_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  wire logic                     clock,
  input  wire logic                     reset,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic [WIDTH-1:0]         din,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic [WIDTH-1:0]              head
);
  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;

  always_ff @(posedge clock) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign full  = (r_count == (c_aw+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
//  Module : dmem_mmio_responder
//  Routes processor dmem accesses to the syncram or to an MMIO window
//  (LED, cycle timer, TX FIFO, STATUS). Timer present when MMIO_TIMER_EN
//  is defined. DATA_WIDTH must be at least 32.
//  Rev 1.0
// ============================================================================
module dmem_mmio_responder
  import dmem_mmio_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = ADDR_WIDTH'(DEFAULT_MMIO_BASE),
  parameter int                    LED_WIDTH  = 16,
  parameter int                    FIFO_DEPTH = 8
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  dmem_mmio_responder_if.slave       proc,
  output logic [ADDR_WIDTH-1:0]      mem_address,
  output logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       mem_wren,
  input  wire logic [DATA_WIDTH-1:0] mem_q,
  output logic [LED_WIDTH-1:0]       led_out,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  wire logic                  tx_ready
);
  localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

  logic                  w_in_mmio;
  logic [ADDR_WIDTH-1:0] w_ofs;
  logic                  w_wr_led, w_wr_timer, w_wr_tx, w_wr_status;
  logic                  w_push, w_pop, w_full, w_empty;
  logic [c_cw-1:0]       w_count;
  logic [31:0]           w_timer;
  logic [DATA_WIDTH-1:0] w_status, w_rdata;

  logic [LED_WIDTH-1:0]  r_led;
  logic                  r_overflow;
  logic                  r_sel_mmio;
  logic [DATA_WIDTH-1:0] r_mmio_rdata;

  assign w_in_mmio   = (proc.address >= MMIO_BASE);
  assign w_ofs       = proc.address - MMIO_BASE;
  assign w_wr_led    = proc.wren && w_in_mmio && (w_ofs == ADDR_WIDTH'(OFS_LED));
  assign w_wr_timer  = proc.wren && w_in_mmio && (w_ofs == ADDR_WIDTH'(OFS_TIMER));
  assign w_wr_tx     = proc.wren && w_in_mmio && (w_ofs == ADDR_WIDTH'(OFS_TXDATA));
  assign w_wr_status = proc.wren && w_in_mmio && (w_ofs == ADDR_WIDTH'(OFS_STATUS));

  assign mem_address = proc.address;
  assign mem_data    = proc.data;
  assign mem_wren    = proc.wren && !w_in_mmio;

  // A push into a full FIFO is still taken when the head leaves the same cycle
  assign w_pop  = tx_valid && tx_ready;
  assign w_push = w_wr_tx && (!w_full || w_pop);

  mmio_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (proc.data[7:0]),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .head  (tx_data)
  );

  assign tx_valid = !w_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_led      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_led) r_led <= proc.data[LED_WIDTH-1:0];
      if (w_wr_status)
        r_overflow <= 1'b0;
      else if (w_wr_tx && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  assign led_out = r_led;

`ifdef MMIO_TIMER_EN
  logic [31:0] r_timer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           r_timer <= '0;
    else if (w_wr_timer) r_timer <= '0;
    else                 r_timer <= r_timer + 32'd1;
  end

  assign w_timer = r_timer;
`else
  assign w_timer = '0;
`endif

  always_comb begin
    w_status = '0;
    w_status[STATUS_OVF_BIT]  = r_overflow;
    w_status[STATUS_FULL_BIT] = w_full;
    w_status[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(w_count);
  end

  always_comb begin
    w_rdata = '0;
    if (w_in_mmio) begin
      case (w_ofs)
        ADDR_WIDTH'(OFS_LED):    w_rdata = DATA_WIDTH'(r_led);
        ADDR_WIDTH'(OFS_TIMER):  w_rdata = DATA_WIDTH'(w_timer);
        ADDR_WIDTH'(OFS_STATUS): w_rdata = w_status;
        default:                 w_rdata = '0;
      endcase
    end
  end

  // Register value is captured before this edge's write lands
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sel_mmio   <= 1'b0;
      r_mmio_rdata <= '0;
    end else begin
      r_sel_mmio   <= w_in_mmio;
      r_mmio_rdata <= w_rdata;
    end
  end

  assign proc.q = r_sel_mmio ? r_mmio_rdata : mem_q;

endmodule
`default_nettype wire
